// File: rtl/pingpong_buffer.sv
// Ping-pong staging buffer: two banks, producer fills one while consumer drains the other.
// Optional build macro PINGPONG_WR_MASK_EN enables per-lane write masking via wr_mask.
module pingpong_buffer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 64,
    parameter int LANE_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_en,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0] wr_mask,
    input  logic                             wr_done,
    output logic                             wr_ready,
    output logic                             wr_bank,
    input  logic                             rd_en,
    input  logic [ADDR_WIDTH-1:0]            rd_addr,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_valid,
    input  logic                             rd_done,
    output logic                             rd_ready,
    output logic                             rd_bank,
    output logic [1:0]                       level,
    output logic                             err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int LANES = DATA_WIDTH / LANE_WIDTH;

    logic                  wb;
    logic                  rb;
    logic [1:0]            full;
    logic [1:0]            full_nxt;
    logic [DATA_WIDTH-1:0] mem [0:1][0:DEPTH-1];

    logic wr_acc;
    logic commit;
    logic rd_acc;
    logic release_bank;
    logic violation;

    // Status outputs come straight from registered state
    assign wr_ready = !full[wb];
    assign rd_ready = full[rb];
    assign wr_bank  = wb;
    assign rd_bank  = rb;
    assign level    = {1'b0, full[0]} + {1'b0, full[1]};

    assign wr_acc       = wr_en   && wr_ready;
    assign commit       = wr_done && wr_ready;
    assign rd_acc       = rd_en   && rd_ready;
    assign release_bank = rd_done && rd_ready;

    assign violation = ((wr_en || wr_done) && !wr_ready) ||
                       ((rd_en || rd_done) && !rd_ready);

`ifndef PINGPONG_WR_MASK_EN
    logic unused_mask;
    assign unused_mask = ^wr_mask;
`endif

    // Commit sets the write bank, release clears the read bank; they never collide
    always_comb begin
        full_nxt = full;
        if (commit) begin
            full_nxt[wb] = 1'b1;
        end
        if (release_bank) begin
            full_nxt[rb] = 1'b0;
        end
    end

    // Bank pointers, full flags and sticky protocol error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb   <= 1'b0;
            rb   <= 1'b0;
            full <= 2'b00;
            err  <= 1'b0;
        end else begin
            full <= full_nxt;
            if (commit) begin
                wb <= ~wb;
            end
            if (release_bank) begin
                rb <= ~rb;
            end
            if (violation) begin
                err <= 1'b1;
            end
        end
    end

    // Storage write into the current write bank; contents are never reset
    always_ff @(posedge clk) begin
`ifdef PINGPONG_WR_MASK_EN
        for (int k = 0; k < LANES; k++) begin
            if (wr_acc && wr_mask[k]) begin
                mem[wb][wr_addr][k*LANE_WIDTH +: LANE_WIDTH] <=
                    wr_data[k*LANE_WIDTH +: LANE_WIDTH];
            end
        end
`else
        if (wr_acc) begin
            mem[wb][wr_addr] <= wr_data;
        end
`endif
    end

    // Registered read; captured before any same-cycle release takes effect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                rd_data <= mem[rb][rd_addr];
            end
        end
    end

endmodule
